irrigation_zone_sequencer: RTL and testbench

- Parametrised successor of the single-channel irrigation main state machine.
- Sweeps ZONES irrigation zones in ascending order and runs each zone's requested programme: sprinkler, drip, or sprinkler then drip.
- Each watered zone ends with a timed flush phase.
- Phase durations come from an internal tick-driven countdown timer instead of an external time_over input.
- Adds a water-supply fault state and an abort path.
- Sits between the user-interface/mode registers and the valve drivers.

---
 rtl/irrigation_pkg.sv | 21 ++
 rtl/phase_timer.sv | 28 ++
 rtl/irrigation_zone_sequencer.sv | 177 +++++++++++++++++
 tb/tb_irrigation_zone_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irrigation_pkg.sv
// Shared state and zone-mode encodings for the irrigation zone sequencer.
// Optional pause input is selected by IRRIGATION_PAUSE_EN in the top module.
package irrigation_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SCAN     = 3'd1,
        ST_SPRINKLE = 3'd2,
        ST_DRIP     = 3'd3,
        ST_FLUSH    = 3'd4,
        ST_FAULT    = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        MODE_NONE     = 2'b00,
        MODE_SPRINKLE = 2'b01,
        MODE_DRIP     = 2'b10,
        MODE_BOTH     = 2'b11
    } mode_t;

endpackage

// File: rtl/phase_timer.sv
// Loadable tick-driven down-counter; expire fires on the tick that consumes the last count.
module phase_timer #(
    parameter int unsigned TIMER_W = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_value,
    input  logic               tick,
    input  logic               hold,
    output logic               expire
);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (tick && !hold && count != '0) begin
            count <= count - TIMER_W'(1);
        end
    end

    assign expire = tick && !hold && (count == TIMER_W'(1));

endmodule

// File: rtl/irrigation_zone_sequencer.sv
// Sweeps ZONES zones in order, running sprinkler/drip programmes followed by a flush.
// Define IRRIGATION_PAUSE_EN to add the pause input (freezes timer, closes valves).
module irrigation_zone_sequencer
    import irrigation_pkg::*;
#(
    parameter int unsigned ZONES          = 4,
    parameter int unsigned TIMER_W        = 16,
    parameter int unsigned SPRINKLE_TICKS = 600,
    parameter int unsigned DRIP_TICKS     = 1200,
    parameter int unsigned FLUSH_TICKS    = 60
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               tick,
    input  logic               enable,
    input  logic [2*ZONES-1:0] zone_mode,
    input  logic               tank_low,
`ifdef IRRIGATION_PAUSE_EN
    input  logic               pause,
`endif
    output logic [2:0]         state,
    output logic [ZONES-1:0]   zone_sel,
    output logic               valve_sprinkle,
    output logic               valve_drip,
    output logic               valve_flush,
    output logic               done
);

    localparam int unsigned      PTR_W     = (ZONES > 1) ? $clog2(ZONES) : 1;
    localparam logic [PTR_W-1:0] LAST_ZONE = PTR_W'(ZONES - 1);

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    mode_t              mode_q, mode_d;
    logic               done_q, done_d;
    logic               load;
    logic [TIMER_W-1:0] load_value;
    logic               expire;
    logic               in_phase;
    logic               paused;
    logic               pause_w;
    mode_t              scan_mode;

`ifdef IRRIGATION_PAUSE_EN
    assign pause_w = pause;
`else
    assign pause_w = 1'b0;
`endif

    assign in_phase  = (state_q == ST_SPRINKLE) || (state_q == ST_DRIP) || (state_q == ST_FLUSH);
    assign paused    = in_phase && pause_w;
    assign scan_mode = mode_t'(zone_mode[{ptr_q, 1'b0} +: 2]);

    phase_timer #(.TIMER_W(TIMER_W)) u_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (load),
        .load_value (load_value),
        .tick       (tick),
        .hold       (paused || (state_q == ST_FAULT)),
        .expire     (expire)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            mode_q  <= MODE_NONE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        mode_d     = mode_q;
        done_d     = 1'b0;
        load       = 1'b0;
        load_value = '0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_SCAN;
                    ptr_d   = '0;
                end
            end
            ST_SCAN: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end else begin
                    mode_d = scan_mode;
                    case (scan_mode)
                        MODE_NONE: begin
                            if (ptr_q == LAST_ZONE) begin
                                state_d = ST_IDLE;
                                ptr_d   = '0;
                                done_d  = 1'b1;
                            end else begin
                                ptr_d = ptr_q + PTR_W'(1);
                            end
                        end
                        MODE_DRIP: begin
                            state_d    = ST_DRIP;
                            load       = 1'b1;
                            load_value = TIMER_W'(DRIP_TICKS);
                        end
                        default: begin
                            state_d    = ST_SPRINKLE;
                            load       = 1'b1;
                            load_value = TIMER_W'(SPRINKLE_TICKS);
                        end
                    endcase
                end
            end
            ST_SPRINKLE: begin
                // Supply fault outranks pause; pause outranks enable and expiry.
                if (tank_low) begin
                    state_d = ST_FAULT;
                end else if (!paused && (!enable || expire)) begin
                    load = 1'b1;
                    if (enable && mode_q == MODE_BOTH) begin
                        state_d    = ST_DRIP;
                        load_value = TIMER_W'(DRIP_TICKS);
                    end else begin
                        state_d    = ST_FLUSH;
                        load_value = TIMER_W'(FLUSH_TICKS);
                    end
                end
            end
            ST_DRIP: begin
                if (tank_low) begin
                    state_d = ST_FAULT;
                end else if (!paused && (!enable || expire)) begin
                    state_d    = ST_FLUSH;
                    load       = 1'b1;
                    load_value = TIMER_W'(FLUSH_TICKS);
                end
            end
            ST_FLUSH: begin
                if (expire) begin
                    if (ptr_q == LAST_ZONE || !enable) begin
                        state_d = ST_IDLE;
                        ptr_d   = '0;
                        done_d  = (ptr_q == LAST_ZONE) && enable;
                    end else begin
                        state_d = ST_SCAN;
                        ptr_d   = ptr_q + PTR_W'(1);
                    end
                end
            end
            ST_FAULT: begin
                if (!tank_low && !enable) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    assign state          = state_q;
    assign zone_sel       = in_phase ? (ZONES'(1) << ptr_q) : '0;
    assign valve_sprinkle = (state_q == ST_SPRINKLE) && !pause_w;
    assign valve_drip     = (state_q == ST_DRIP) && !pause_w;
    assign valve_flush    = (state_q == ST_FLUSH) && !pause_w;
    assign done           = done_q;

endmodule

// File: tb/tb_irrigation_zone_sequencer.sv
// Self-checking bench: reset/table vectors, directed multi-cycle sequences, randomized model run.
// Define IRRIGATION_PAUSE_EN to also exercise the pause input.
module tb_irrigation_zone_sequencer;

    localparam int NZ = 4;
    localparam int S_TICKS = 3;
    localparam int D_TICKS = 2;
    localparam int F_TICKS = 1;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] zone_mode = '0;
    logic       tank_low = 1'b0;
`ifdef IRRIGATION_PAUSE_EN
    logic       pause = 1'b0;
`endif
    logic [2:0] state;
    logic [3:0] zone_sel;
    logic       valve_sprinkle, valve_drip, valve_flush, done;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    irrigation_zone_sequencer #(
        .ZONES          (NZ),
        .TIMER_W        (16),
        .SPRINKLE_TICKS (S_TICKS),
        .DRIP_TICKS     (D_TICKS),
        .FLUSH_TICKS    (F_TICKS)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .tick           (tick),
        .enable         (enable),
        .zone_mode      (zone_mode),
        .tank_low       (tank_low),
`ifdef IRRIGATION_PAUSE_EN
        .pause          (pause),
`endif
        .state          (state),
        .zone_sel       (zone_sel),
        .valve_sprinkle (valve_sprinkle),
        .valve_drip     (valve_drip),
        .valve_flush    (valve_flush),
        .done           (done)
    );

    typedef struct {
        logic       en;
        logic [7:0] zm;
        logic       tl;
        logic       tk;
        logic [2:0] st;
        logic [3:0] sel;
        logic [2:0] vlv;
        logic       dn;
    } vec_t;

    vec_t tbl[6];

    // Reference model: phase code, zone index, remaining ticks, latched programme.
    int m_st, m_ptr, m_left, m_mode, m_done;

    task automatic check(input string name, input logic [2:0] st, input logic [3:0] sel,
                         input logic [2:0] vlv, input logic dn);
        logic [10:0] act;
        logic [10:0] req;
        act = {state, zone_sel, valve_sprinkle, valve_drip, valve_flush, done};
        req = {st, sel, vlv, dn};
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got state=%0d zone_sel=%b valves(s,d,f)=%b done=%b, want state=%0d zone_sel=%b valves=%b done=%b",
                     name, state, zone_sel, {valve_sprinkle, valve_drip, valve_flush}, done, st, sel, vlv, dn);
        end
    endtask

    task automatic cyc(input logic t);
        tick = t;
        @(posedge clock);
        @(negedge clock);
        tick = 1'b0;
    endtask

    task automatic tick_period();
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b1);
    endtask

    function automatic logic cur_pause();
`ifdef IRRIGATION_PAUSE_EN
        return pause;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_step(input logic en, input logic [7:0] zm, input logic tl,
                              input logic tk, input logic ps);
        int md;
        m_done = 0;
        case (m_st)
            0: if (en) begin m_st = 1; m_ptr = 0; end
            1: begin
                if (!en) begin
                    m_st = 0; m_ptr = 0;
                end else begin
                    md = (int'(zm) >> (2 * m_ptr)) & 3;
                    m_mode = md;
                    if (md == 0) begin
                        if (m_ptr == NZ - 1) begin m_st = 0; m_ptr = 0; m_done = 1; end
                        else m_ptr = m_ptr + 1;
                    end else if (md == 2) begin
                        m_st = 3; m_left = D_TICKS;
                    end else begin
                        m_st = 2; m_left = S_TICKS;
                    end
                end
            end
            2, 3: begin
                if (tl) m_st = 5;
                else if (ps) ;
                else if (!en) begin m_st = 4; m_left = F_TICKS; end
                else if (tk) begin
                    if (m_left > 1) m_left = m_left - 1;
                    else if (m_st == 2 && m_mode == 3) begin m_st = 3; m_left = D_TICKS; end
                    else begin m_st = 4; m_left = F_TICKS; end
                end
            end
            4: begin
                if (!ps && tk) begin
                    if (m_left > 1) m_left = m_left - 1;
                    else if (m_ptr == NZ - 1 || !en) begin
                        m_done = (m_ptr == NZ - 1 && en) ? 1 : 0;
                        m_st = 0; m_ptr = 0;
                    end else begin
                        m_st = 1; m_ptr = m_ptr + 1;
                    end
                end
            end
            default: if (!tl && !en) begin m_st = 0; m_ptr = 0; end
        endcase
    endtask

    initial begin
        logic [3:0] exp_sel;
        logic [2:0] exp_vlv;
        logic       ps;

        // Reset state
        @(negedge clock);
        check("reset_state", 3'd0, 4'b0000, 3'b000, 1'b0);
        reset_n = 1'b1;
        cyc(1'b0);
        check("idle_after_reset", 3'd0, 4'b0000, 3'b000, 1'b0);

        // Asynchronous reset during a sprinkler phase
        zone_mode = 8'b00_00_00_01;
        enable = 1'b1;
        cyc(1'b0);
        cyc(1'b0);
        check("t1_sprinkle", 3'd2, 4'b0001, 3'b100, 1'b0);
        cyc(1'b1);
        #2 reset_n = 1'b0;
        #1 check("t1_async_reset", 3'd0, 4'b0000, 3'b000, 1'b0);
        enable = 1'b0;
        #1 reset_n = 1'b1;
        @(negedge clock);
        cyc(1'b0);
        check("t1_idle_after_release", 3'd0, 4'b0000, 3'b000, 1'b0);

        // Empty sweep, table driven
        tbl[0] = '{1'b1, 8'h00, 1'b0, 1'b0, 3'd1, 4'b0000, 3'b000, 1'b0};
        tbl[1] = '{1'b1, 8'h00, 1'b0, 1'b0, 3'd1, 4'b0000, 3'b000, 1'b0};
        tbl[2] = '{1'b1, 8'h00, 1'b0, 1'b1, 3'd1, 4'b0000, 3'b000, 1'b0};
        tbl[3] = '{1'b1, 8'h00, 1'b0, 1'b0, 3'd1, 4'b0000, 3'b000, 1'b0};
        tbl[4] = '{1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 4'b0000, 3'b000, 1'b1};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 4'b0000, 3'b000, 1'b0};
        for (int i = 0; i < 6; i++) begin
            enable = tbl[i].en;
            zone_mode = tbl[i].zm;
            tank_low = tbl[i].tl;
            cyc(tbl[i].tk);
            check($sformatf("t2_table[%0d]", i), tbl[i].st, tbl[i].sel, tbl[i].vlv, tbl[i].dn);
        end

        // Zone 1 sprinkler then drip
        zone_mode = 8'b00_00_11_00;
        enable = 1'b1;
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b0);
        check("t3_sprinkle_entry", 3'd2, 4'b0010, 3'b100, 1'b0);
        tick_period();
        tick_period();
        check("t3_sprinkle_tick2", 3'd2, 4'b0010, 3'b100, 1'b0);
        tick_period();
        check("t3_drip_entry", 3'd3, 4'b0010, 3'b010, 1'b0);
        tick_period();
        check("t3_drip_tick1", 3'd3, 4'b0010, 3'b010, 1'b0);
        tick_period();
        check("t3_flush_entry", 3'd4, 4'b0010, 3'b001, 1'b0);
        tick_period();
        check("t3_scan_zone2", 3'd1, 4'b0000, 3'b000, 1'b0);
        cyc(1'b0);
        cyc(1'b0);
        check("t3_done", 3'd0, 4'b0000, 3'b000, 1'b1);
        enable = 1'b0;
        cyc(1'b0);
        check("t3_done_single", 3'd0, 4'b0000, 3'b000, 1'b0);

        // Supply fault during drip of zone 0
        zone_mode = 8'b00_00_00_10;
        enable = 1'b1;
        cyc(1'b0);
        cyc(1'b0);
        check("t4_drip_entry", 3'd3, 4'b0001, 3'b010, 1'b0);
        tick_period();
        tank_low = 1'b1;
        cyc(1'b0);
        check("t4_fault", 3'd5, 4'b0000, 3'b000, 1'b0);
        tank_low = 1'b0;
        cyc(1'b1);
        cyc(1'b0);
        check("t4_fault_hold_enable", 3'd5, 4'b0000, 3'b000, 1'b0);
        enable = 1'b0;
        cyc(1'b0);
        check("t4_fault_exit", 3'd0, 4'b0000, 3'b000, 1'b0);
        zone_mode = 8'b00_00_00_01;
        enable = 1'b1;
        cyc(1'b0);
        cyc(1'b0);
        check("t4_ptr_zero", 3'd2, 4'b0001, 3'b100, 1'b0);
        enable = 1'b0;
        cyc(1'b0);
        tick_period();
        check("t4_back_idle", 3'd0, 4'b0000, 3'b000, 1'b0);

        // Enable dropped during zone 2 sprinkler; tank_low ignored in flush
        zone_mode = 8'b00_01_00_00;
        enable = 1'b1;
        for (int i = 0; i < 4; i++) cyc(1'b0);
        check("t5_sprinkle_z2", 3'd2, 4'b0100, 3'b100, 1'b0);
        tick_period();
        enable = 1'b0;
        cyc(1'b0);
        check("t5_flush", 3'd4, 4'b0100, 3'b001, 1'b0);
        tank_low = 1'b1;
        cyc(1'b0);
        cyc(1'b0);
        check("t5_flush_ignores_tank", 3'd4, 4'b0100, 3'b001, 1'b0);
        cyc(1'b1);
        check("t5_idle_no_done", 3'd0, 4'b0000, 3'b000, 1'b0);
        tank_low = 1'b0;

`ifdef IRRIGATION_PAUSE_EN
        zone_mode = 8'b00_00_00_01;
        enable = 1'b1;
        cyc(1'b0);
        cyc(1'b0);
        tick_period();
        pause = 1'b1;
        #1 check("t6_pause_valves", 3'd2, 4'b0001, 3'b000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick_period();
            check($sformatf("t6_paused_tick%0d", i), 3'd2, 4'b0001, 3'b000, 1'b0);
        end
        pause = 1'b0;
        #1 check("t6_resume", 3'd2, 4'b0001, 3'b100, 1'b0);
        tick_period();
        check("t6_remaining1", 3'd2, 4'b0001, 3'b100, 1'b0);
        tick_period();
        check("t6_expire", 3'd4, 4'b0001, 3'b001, 1'b0);
        enable = 1'b0;
        tick_period();
        check("t6_idle", 3'd0, 4'b0000, 3'b000, 1'b0);
`endif

        // Randomized run against the reference model
        reset_n = 1'b0;
        enable = 1'b0;
        tank_low = 1'b0;
        cyc(1'b0);
        reset_n = 1'b1;
        cyc(1'b0);
        m_st = 0; m_ptr = 0; m_left = 0; m_mode = 0; m_done = 0;
        enable = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom % 40 == 0) enable = ~enable;
            tank_low = ($urandom % 60 == 0);
            if ($urandom % 10 == 0) zone_mode = 8'($urandom);
`ifdef IRRIGATION_PAUSE_EN
            pause = ($urandom % 12 == 0);
`endif
            tick = ($urandom % 3 == 0);
            model_step(enable, zone_mode, tank_low, tick, cur_pause());
            @(posedge clock);
            @(negedge clock);
            ps = cur_pause();
            exp_sel = (m_st >= 2 && m_st <= 4) ? 4'(1 << m_ptr) : 4'b0000;
            exp_vlv = {m_st == 2 && !ps, m_st == 3 && !ps, m_st == 4 && !ps};
            check($sformatf("rand[%0d]", n), 3'(m_st), exp_sel, exp_vlv, 1'(m_done));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
